// File: rtl/dma_seq_ctrl.sv
// Per-burst DMA sequencer: start -> clear/init strobes, then per burst REQ/ack, BEATS data beats, step strobes, done.
// Setup costs 3 cycles, each burst at least BEATS+3; an unacked request stalls in REQ and rvalid gaps stall in DATA.
module dma_seq_ctrl #(
    parameter int  BURSTS_W = 4,
    parameter int  BEATS    = 4,
    localparam int BIDX_W   = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                clk_h,
    input  logic                rst_n,
    input  logic                start,
    input  logic                tgt,
    input  logic [BURSTS_W-1:0] num_bursts,
    input  logic                abort,
    output logic                sdram_req,
    input  logic                sdram_ack,
    input  logic                sdram_rvalid,
    output logic                mem_we,
    output logic                mem_sel,
    output logic [BIDX_W-1:0]   beat_idx,
    output logic                clear_addr,
    output logic                init_sdram_addr,
    output logic                init_mem1_addr,
    output logic                init_mem2_addr,
    output logic                add_sdram_addr,
    output logic                add_mem1_addr,
    output logic                add_mem2_addr,
    output logic                busy,
    output logic                done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_INIT_SD,
        S_INIT_MEM,
        S_REQ,
        S_DATA,
        S_STEP_SD,
        S_STEP_MEM,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [BURSTS_W-1:0]   remaining_q, remaining_d;
    logic [BIDX_W-1:0]     beat_idx_q, beat_idx_d;
    logic                  mem_sel_q, mem_sel_d;

    always_ff @(posedge clk_h or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            beat_idx_q  <= '0;
            mem_sel_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            beat_idx_q  <= beat_idx_d;
            mem_sel_q   <= mem_sel_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        beat_idx_d  = beat_idx_q;
        mem_sel_d   = mem_sel_q;
        if (abort) begin
            state_d     = S_IDLE;
            remaining_d = '0;
            beat_idx_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mem_sel_d = tgt;
                        if (num_bursts != '0) begin
                            remaining_d = num_bursts;
                            state_d     = S_CLEAR;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_CLEAR:    state_d = S_INIT_SD;
                S_INIT_SD:  state_d = S_INIT_MEM;
                S_INIT_MEM: state_d = S_REQ;
                S_REQ: begin
                    if (sdram_ack) begin
                        beat_idx_d = '0;
                        state_d    = S_DATA;
                    end
                end
                S_DATA: begin
                    if (sdram_rvalid) begin
                        if (beat_idx_q == BIDX_W'(BEATS - 1)) begin
                            beat_idx_d = '0;
                            state_d    = S_STEP_SD;
                        end else begin
                            beat_idx_d = beat_idx_q + BIDX_W'(1);
                        end
                    end
                end
                S_STEP_SD:  state_d = S_STEP_MEM;
                S_STEP_MEM: begin
                    if (remaining_q != '0) begin
                        remaining_d = remaining_q - BURSTS_W'(1);
                    end
                    // a count of 0 here can only follow corruption; finish rather than spin
                    state_d = (remaining_q <= BURSTS_W'(1)) ? S_DONE : S_REQ;
                end
                S_DONE:     state_d = S_IDLE;
                default:    state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        sdram_req       = 1'b0;
        mem_we          = 1'b0;
        clear_addr      = 1'b0;
        init_sdram_addr = 1'b0;
        init_mem1_addr  = 1'b0;
        init_mem2_addr  = 1'b0;
        add_sdram_addr  = 1'b0;
        add_mem1_addr   = 1'b0;
        add_mem2_addr   = 1'b0;
        done            = 1'b0;
        busy            = (state_q != S_IDLE);
        case (state_q)
            S_CLEAR:    clear_addr      = 1'b1;
            S_INIT_SD:  init_sdram_addr = 1'b1;
            S_INIT_MEM: begin
                init_mem1_addr = ~mem_sel_q;
                init_mem2_addr =  mem_sel_q;
            end
            S_REQ:      sdram_req       = 1'b1;
            S_DATA:     mem_we          = sdram_rvalid;
            S_STEP_SD:  add_sdram_addr  = 1'b1;
            S_STEP_MEM: begin
                add_mem1_addr = ~mem_sel_q;
                add_mem2_addr =  mem_sel_q;
            end
            S_DONE:     done            = 1'b1;
            default:    ;
        endcase
    end

    assign mem_sel  = mem_sel_q;
    assign beat_idx = beat_idx_q;

endmodule

// File: tb/tb_dma_seq_ctrl.sv
// Bench for dma_seq_ctrl: a token-script model of the transfer checked every cycle, plus directed scenarios.
`timescale 1ns/1ps
module tb_dma_seq_ctrl;
    localparam int BW    = 4;
    localparam int BEATS = 4;

    logic          clk_h = 1'b0, rst_n = 1'b0;
    logic          start = 1'b0, tgt = 1'b0, abort = 1'b0;
    logic [BW-1:0] num_bursts = '0;
    logic          sdram_ack = 1'b0, sdram_rvalid = 1'b0;
    logic          sdram_req, mem_we, mem_sel, busy, done;
    logic [1:0]    beat_idx;
    logic          clear_addr, init_sdram_addr, init_mem1_addr, init_mem2_addr;
    logic          add_sdram_addr, add_mem1_addr, add_mem2_addr;

    dma_seq_ctrl #(.BURSTS_W(BW), .BEATS(BEATS)) dut (
        .clk_h(clk_h), .rst_n(rst_n), .start(start), .tgt(tgt),
        .num_bursts(num_bursts), .abort(abort),
        .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_rvalid(sdram_rvalid),
        .mem_we(mem_we), .mem_sel(mem_sel), .beat_idx(beat_idx),
        .clear_addr(clear_addr), .init_sdram_addr(init_sdram_addr),
        .init_mem1_addr(init_mem1_addr), .init_mem2_addr(init_mem2_addr),
        .add_sdram_addr(add_sdram_addr), .add_mem1_addr(add_mem1_addr),
        .add_mem2_addr(add_mem2_addr), .busy(busy), .done(done)
    );

    always #5 clk_h = ~clk_h;

    logic [13:0] dvec;
    assign dvec = {busy, done, sdram_req, mem_we, mem_sel, beat_idx,
                   clear_addr, init_sdram_addr, init_mem1_addr, init_mem2_addr,
                   add_sdram_addr, add_mem1_addr, add_mem2_addr};

    // Model: an accepted start expands into a script of steps; each cycle the head step
    // defines the outputs, REQ waits for ack, a DATA step waits for a beat, others take one cycle.
    localparam int T_CLR = 0, T_ISD = 1, T_IMEM = 2, T_REQ = 3, T_SSD = 4, T_SMEM = 5, T_DONE = 6, T_DATA = 16;
    int   q[$];
    logic m_sel = 1'b0;

    always @(posedge clk_h or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_sel = 1'b0;
        end else if (abort) begin
            q.delete();
        end else if (q.size() == 0) begin
            if (start) begin
                m_sel = tgt;
                for (int b = 0; b < int'(num_bursts); b++) begin
                    if (b == 0) begin
                        q.push_back(T_CLR); q.push_back(T_ISD); q.push_back(T_IMEM);
                    end
                    q.push_back(T_REQ);
                    for (int k = 0; k < BEATS; k++) q.push_back(T_DATA + k);
                    q.push_back(T_SSD); q.push_back(T_SMEM);
                end
                q.push_back(T_DONE);
            end
        end else if (q[0] == T_REQ) begin
            if (sdram_ack) void'(q.pop_front());
        end else if (q[0] >= T_DATA) begin
            if (sdram_rvalid) void'(q.pop_front());
        end else begin
            void'(q.pop_front());
        end
    end

    function automatic logic [13:0] exp_vec();
        logic [6:0] s;
        logic [1:0] bi;
        int         f;
        if (q.size() == 0) return {4'b0000, m_sel, 2'b00, 7'b0};
        f  = q[0];
        s  = '0;
        bi = (f >= T_DATA) ? 2'(f - T_DATA) : 2'd0;
        case (f)
            T_CLR:  s[6] = 1'b1;
            T_ISD:  s[5] = 1'b1;
            T_IMEM: if (m_sel) s[3] = 1'b1; else s[4] = 1'b1;
            T_SSD:  s[2] = 1'b1;
            T_SMEM: if (m_sel) s[0] = 1'b1; else s[1] = 1'b1;
            default: ;
        endcase
        return {1'b1, f == T_DONE, f == T_REQ, (f >= T_DATA) && sdram_rvalid, m_sel, bi, s};
    endfunction

    // Reactive SDRAM side: 0 = always ack/valid, 1 = ack on 3rd REQ cycle + rvalid 1,0,1,1,0,1, 2 = quiet
    int mode = 2;
    always @(posedge clk_h) begin
        int         req_cnt;
        int         pidx;
        logic [5:0] pat;
        #1;
        pat = 6'b101101;
        case (mode)
            0: begin sdram_ack = 1'b1; sdram_rvalid = 1'b1; end
            1: begin
                req_cnt      = sdram_req ? req_cnt + 1 : 0;
                sdram_ack    = (req_cnt >= 3);
                sdram_rvalid = pat[5 - pidx];
                pidx         = (pidx + 1) % 6;
            end
            default: begin sdram_ack = 1'b0; sdram_rvalid = 1'b0; end
        endcase
    end

    localparam int C_WE = 0, C_CLR = 1, C_ISD = 2, C_IM1 = 3, C_IM2 = 4, C_ASD = 5,
                   C_AM1 = 6, C_AM2 = 7, C_DONE = 8, C_REQ = 9, C_BUSY = 10, C_MULTI = 11;
    int       cnt [12];
    int       base[12];
    int       n_chk = 0, n_pass = 0;
    int       ncyc = 0, t_start = 0, d_cyc = 0;
    logic [7:0] beat_log = '0;

    function automatic int d(input int i);
        return cnt[i] - base[i];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic sample();
        ncyc++;
        if (rst_n) begin
            chk($sformatf("cycle%0d_outputs", ncyc), 32'(dvec), 32'(exp_vec()));
            if (q.size() == 0 && start && !abort) t_start = ncyc;
            if (done) begin d_cyc = ncyc; cnt[C_DONE]++; end
            if (mem_we) begin cnt[C_WE]++; beat_log = {beat_log[5:0], beat_idx}; end
            if (clear_addr)      cnt[C_CLR]++;
            if (init_sdram_addr) cnt[C_ISD]++;
            if (init_mem1_addr)  cnt[C_IM1]++;
            if (init_mem2_addr)  cnt[C_IM2]++;
            if (add_sdram_addr)  cnt[C_ASD]++;
            if (add_mem1_addr)   cnt[C_AM1]++;
            if (add_mem2_addr)   cnt[C_AM2]++;
            if (sdram_req)       cnt[C_REQ]++;
            if (busy)            cnt[C_BUSY]++;
            if ($countones(dvec[6:0]) > 1) cnt[C_MULTI]++;
        end
    endtask

    // Called at posedge+1; start is sampled at the following edge.
    task automatic start_cmd(input logic t, input logic [BW-1:0] n);
        tgt = t; num_bursts = n; start = 1'b1;
        @(posedge clk_h); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk_h); #1;
            if (done) seen = 1'b1;
        end
        chk({nm, "_done_seen"}, 32'(seen), 32'd1);
        @(posedge clk_h); #1;
    endtask

    task automatic main_seq();
        bit seen;
        repeat (2) @(negedge clk_h);
        #1 chk("reset_outputs", 32'(dvec), 32'd0);
        @(negedge clk_h); #1 rst_n = 1'b1;

        // asynchronous reset while data is streaming
        mode = 0;
        @(posedge clk_h); #1;
        start_cmd(1'b0, 4'd2);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk_h); #1;
            if (mem_we) seen = 1'b1;
        end
        chk("reach_data", 32'(seen), 32'd1);
        @(posedge clk_h); #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", 32'(dvec), 32'd0);
        @(negedge clk_h); #1 rst_n = 1'b1;

        // single burst, mem1, no stalls
        @(posedge clk_h); #1;
        base = cnt;
        start_cmd(1'b0, 4'd1);
        wait_done(60, "single");
        chk("single_latency", d_cyc - t_start, 32'd11);
        chk("single_we", d(C_WE), 32'd4);
        chk("single_beat_order", 32'(beat_log), 32'h1B);
        chk("single_clr_isd_im1", {8'(d(C_CLR)), 8'(d(C_ISD)), 8'(d(C_IM1))}, 32'h010101);
        chk("single_asd_am1", {8'(d(C_ASD)), 8'(d(C_AM1))}, 32'h0101);
        chk("single_mem2_strobes", d(C_IM2) + d(C_AM2), 32'd0);
        chk("single_done", d(C_DONE), 32'd1);
        chk("single_multi_strobe", d(C_MULTI), 32'd0);

        // three bursts to mem2, delayed ack and gappy rvalid, started right after DONE
        mode = 1;
        base = cnt;
        start_cmd(1'b1, 4'd3);
        wait_done(300, "multi");
        chk("multi_we", d(C_WE), 32'd12);
        chk("multi_asd", d(C_ASD), 32'd3);
        chk("multi_am2", d(C_AM2), 32'd3);
        chk("multi_im2", d(C_IM2), 32'd1);
        chk("multi_mem1_strobes", d(C_IM1) + d(C_AM1), 32'd0);
        chk("multi_done", d(C_DONE), 32'd1);
        chk("multi_multi_strobe", d(C_MULTI), 32'd0);

        // zero-burst command
        mode = 0;
        base = cnt;
        start_cmd(1'b1, 4'd0);
        wait_done(10, "zero");
        chk("zero_latency", d_cyc - t_start, 32'd1);
        chk("zero_strobes", d(C_CLR) + d(C_ISD) + d(C_IM1) + d(C_IM2) + d(C_ASD) + d(C_AM1) + d(C_AM2), 32'd0);
        chk("zero_req", d(C_REQ), 32'd0);
        chk("zero_busy_cycles", d(C_BUSY), 32'd1);

        // abort during the second burst's first data beat
        base = cnt;
        start_cmd(1'b0, 4'd3);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk_h); #1;
            if (d(C_REQ) >= 2) seen = 1'b1;
        end
        chk("abort_reach_req2", 32'(seen), 32'd1);
        @(posedge clk_h); #1 abort = 1'b1;
        @(posedge clk_h); #1 abort = 1'b0;
        @(negedge clk_h); #1;
        chk("abort_idle", {31'd0, busy}, 32'd0);
        chk("abort_req_dropped", {31'd0, sdram_req}, 32'd0);
        repeat (4) @(negedge clk_h);
        #1;
        chk("abort_no_done", d(C_DONE), 32'd0);
        chk("abort_we", d(C_WE), 32'd5);
        @(posedge clk_h); #1;
        base = cnt;
        start_cmd(1'b0, 4'd2);
        @(negedge clk_h); #1;
        chk("restart_clear_first", {31'd0, clear_addr}, 32'd1);
        wait_done(100, "restart");
        chk("restart_we", d(C_WE), 32'd8);
        chk("restart_am1", d(C_AM1), 32'd2);
        chk("restart_done", d(C_DONE), 32'd1);

        // start pulses while busy and rvalid outside DATA must change nothing
        base = cnt;
        start_cmd(1'b0, 4'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_h); #1;
            start = (i % 2 == 0); tgt = 1'b1; num_bursts = 4'd5;
        end
        start = 1'b0; tgt = 1'b0;
        wait_done(60, "ignore");
        chk("ignore_latency", d_cyc - t_start, 32'd11);
        chk("ignore_we", d(C_WE), 32'd4);
        chk("ignore_asd_am1", {8'(d(C_ASD)), 8'(d(C_AM1))}, 32'h0101);
        chk("ignore_mem2_strobes", d(C_IM2) + d(C_AM2), 32'd0);
        chk("ignore_done", d(C_DONE), 32'd1);
        repeat (3) @(negedge clk_h);
    endtask

    initial begin
        for (int i = 0; i < 12; i++) begin cnt[i] = 0; base[i] = 0; end
        fork
            forever begin
                @(negedge clk_h);
                sample();
            end
            main_seq();
        join_any
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dma_seq_ctrl.md
# dma_seq_ctrl

Sequencing controller for the DMA address unit: turns a single start command into the per-burst strobe sequence (clear, init, step) the address unit needs, runs a request/acknowledge handshake with the SDRAM side for each burst, and counts data beats into local buffer mem1 or mem2. It sits between the host/command logic and the address unit plus SDRAM interface. It guarantees at most one address-unit strobe per cycle, because the address unit resolves simultaneous strobes by fixed priority and would drop all but one.

## Interface
- BURSTS_W, 4, width of burst count; max transfer is 2^BURSTS_W-1 bursts
- BEATS, 4, data beats per burst (≥2)
- clk_h  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  command pulse; sampled only in IDLE
- tgt  in  1  0 = mem1, 1 = mem2; latched on accepted start
- num_bursts  in  BURSTS_W  burst count; latched on accepted start
- abort  in  1  synchronous abort, any state
- sdram_req  out  1  burst request, held until acknowledged
- sdram_ack  in  1  burst accepted; honoured only while sdram_req=1
- sdram_rvalid  in  1  data beat valid; honoured only in DATA
- mem_we  out  1  write strobe to selected buffer
- mem_sel  out  1  latched tgt
- beat_idx  out  clog2(BEATS)  index of current beat within burst
- clear_addr, init_sdram_addr, init_mem1_addr, init_mem2_addr, add_sdram_addr, add_mem1_addr, add_mem2_addr  out  1 each  one-cycle strobes to address unit
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, CLEAR, INIT_SD, INIT_MEM, REQ, DATA, STEP_SD, STEP_MEM, DONE.
- IDLE: start=1 with num_bursts≠0 → CLEAR, latch tgt and remaining=num_bursts. start=1 with num_bursts=0 → DONE, no address strobes. start=0 → stay.
- CLEAR: clear_addr=1 → INIT_SD.
- INIT_SD: init_sdram_addr=1 → INIT_MEM.
- INIT_MEM: init_mem1_addr (tgt=0) or init_mem2_addr (tgt=1) =1 → REQ.
- REQ: sdram_req=1. Stay until sdram_ack=1, then → DATA with beat_idx=0.
- DATA: each cycle with sdram_rvalid=1 gives mem_we=1 and beat_idx+1. On the beat with beat_idx=BEATS-1 → STEP_SD and beat_idx=0. Gaps (rvalid=0) are allowed and stall.
- STEP_SD: add_sdram_addr=1 → STEP_MEM.
- STEP_MEM: add_mem1_addr or add_mem2_addr per mem_sel, remaining−1. If remaining was 1 → DONE, else → REQ.
- DONE: done=1 → IDLE.
- Outputs are decoded from the state register. mem_we = (state==DATA)&sdram_rvalid.
- Exactly one address strobe is high in CLEAR/INIT_*/STEP_* states. None are high elsewhere.
- abort=1 overrides all transitions: next state IDLE, beat_idx=0, remaining=0, no done pulse. Outputs in the abort cycle itself follow the current state.
- start, tgt and num_bursts are ignored while busy. sdram_ack outside REQ and sdram_rvalid outside DATA are ignored.
- remaining is BURSTS_W wide and never decrements below 0. beat_idx wraps to 0 after BEATS-1.

## Timing
- Reset (async assert): state=IDLE, remaining=0, beat_idx=0, mem_sel=0. All outputs 0.
- Deassertion is synchronous to clk_h.
- Start accepted at edge t: CLEAR at cycle t+1, INIT_SD t+2, INIT_MEM t+3, first sdram_req at t+4.
- Per burst, minimum: 1 REQ cycle (ack same cycle) + BEATS DATA cycles + 2 step cycles = BEATS+3.
- Minimum N-burst transfer, start to done: 3 + N·(BEATS+3) + 1 cycles. With BEATS=4, N=1: done at cycle t+11.
- num_bursts=0: done at t+1, busy high for exactly 1 cycle.
- A new start is accepted in the IDLE cycle immediately after DONE.
- Abort mid-REQ drops sdram_req the cycle after abort is sampled.

## Test plan
- Reset mid-DATA (rst_n low asynchronously) → all outputs 0 immediately. Start after release works normally.
- start, tgt=0, num_bursts=1, ack and rvalid always high → strobe order clear, init_sdram, init_mem1, 4×mem_we (beat_idx 0..3), add_sdram, add_mem1, done at t+11. Never two strobes in one cycle.
- tgt=1, num_bursts=3, ack delayed 2 cycles per burst, rvalid pattern 1,0,1,1,0,1 → exactly 12 mem_we, 3 add_sdram_addr, 3 add_mem2_addr, zero mem1 strobes, single done.
- num_bursts=0 → done one cycle after start, no address strobes, no sdram_req.
- abort in second burst's DATA → IDLE next cycle, no done. Next start with num_bursts=2 begins with clear_addr and completes with 8 mem_we.
- start pulsed while busy, plus sdram_rvalid during REQ/STEP states → ignored; beat and strobe counts unchanged vs. clean run.
